microsequencer: RTL and testbench
=================================

// Module: microsequencer
// PURPOSE
//  Next-address logic for the control unit microstore: owns the microprogram counter (uPC).
//  Drives the 7-bit index into the microstore ROM every cycle and consumes the ROM's
//  sequencing fields to choose the next index. Choices: fetch, decoder entry, increment,
//  conditional branch, wait-on-condition, call or return.
//  Includes a small return stack and a wait watchdog.
// PARAMETERS
//  AW          7     microstore address width (index width)
//  STK_DEPTH   4     return-stack entries (power of 2, 2..8)
//  WAIT_MAX    255   consecutive unsatisfied wait cycles before watchdog fault (>=1)
//  FETCH_ADDR  0     fetch microroutine entry address
//  FAULT_ADDR  0     address forced on watchdog timeout or stack underflow
// PORTS
//  clk        in   1    rising-edge clock, only clock
//  reset_n    in   1    asynchronous active-low reset
//  stall      in   1    1 = freeze uPC, stack, watchdog (index held)
//  ns         in   3    next-state select, from current ROM word (combinational)
//  inv        in   1    invert selected condition
//  cs         in   2    condition select: 00 true, 01 moc, 10 cond_pass, 11 irq_req
//  cr_addr    in   AW   branch/call target from current ROM word
//  enc_addr   in   AW   entry address from instruction decoder
//  moc        in   1    memory operation complete
//  cond_pass  in   1    ARM condition-code check passed
//  irq_req    in   1    pending interrupt request
//  index      out  AW   current uPC, drives ROM address
//  stk_depth  out  3    entries currently on return stack
//  stk_err    out  1    sticky: push when full or pop when empty
//  timeout    out  1    sticky: wait watchdog expired
// BEHAVIOUR
//  Reset (async, reset_n=0): index=FETCH_ADDR, stack empty, stk_depth=0, stk_err=0,
//   timeout=0, wait counter=0. Reset mid-operation discards everything immediately.
//  Timing: index is a register. ROM is combinational, so ns/inv/cs/cr_addr describe
//   the word at index in the same cycle. Next index is loaded on the next rising edge,
//   giving one microinstruction per cycle with zero-bubble branching.
//  c = (selected condition) XOR inv; inc = index+1 mod 2^AW (0x7F -> 0x00).
//  ns encoding (next index when stall=0):
//   000 ENC   : enc_addr
//   001 FETCH : FETCH_ADDR
//   010 INC   : inc
//   011 BR    : c ? cr_addr : inc
//   100 BRENC : c ? enc_addr : inc
//   101 WAIT  : c ? inc : index (hold); see watchdog
//   110 CALL  : push inc, go cr_addr
//   111 RET   : pop, go to popped address
//  Stack: LIFO, depth STK_DEPTH. stk_depth updates on the same edge as index.
//   CALL when full: no push, stk_err<=1, still jumps to cr_addr.
//   RET when empty: stk_err<=1, index<=FAULT_ADDR, depth stays 0.
//  Watchdog: counter increments on each WAIT cycle with c=0, clears on any other
//   non-stalled cycle. If the counter reaches WAIT_MAX on a WAIT cycle with c=0,
//   then on the next edge index<=FAULT_ADDR, timeout<=1, and the counter clears.
//   If c=1 on that same cycle, c wins: go to inc, no timeout.
//  stall=1: all state holds, including counter, stack and sticky flags.
//   Inputs are ignored and index stays stable.
//  Sticky flags clear only on reset.
//  Undefined ns is impossible (3-bit full decode). No X propagation from unused cs.
// TESTING
//  1 reset_n low mid-run (index=0x2A, depth=2) -> index=0, depth=0, flags 0, async
//    (before the next clk edge).
//  2 ns=011, cs=10, cond_pass=1, inv=0, cr_addr=0x5B -> next index=0x5B.
//    Same with inv=1 -> index+1. Also index=0x7F with ns=010 -> 0x00.
//  3 ns=101, cs=01, moc=0 for 3 cycles then 1 -> index holds 3 cycles, then
//    index+1, timeout=0.
//  4 WAIT_MAX=4, moc stuck 0 -> index held exactly 4 cycles, then FAULT_ADDR,
//    timeout=1 thereafter.
//  5 CALL 0x10 from 0x20, then RET -> 0x10 then 0x21, depth 1 then 0.
//    Five nested CALLs (depth 4) -> 5th jumps, stk_err=1, depth=4.
//    RET on empty -> FAULT_ADDR, stk_err=1.
//  6 stall=1 for 3 cycles during ns=010 and during WAIT with counter=2 -> index,
//    counter, depth unchanged; resumes exactly where it stopped.

Source files
------------

// File: rtl/microsequencer_if.sv
// Sequencing bus between the microstore/control side and the microsequencer.
// The master drives the ROM sequencing fields and status inputs; the slave returns uPC and stack status.
interface microsequencer_if #(
    parameter int unsigned AW = 7
);
    logic          stall;
    logic [2:0]    ns;
    logic          inv;
    logic [1:0]    cs;
    logic [AW-1:0] cr_addr;
    logic [AW-1:0] enc_addr;
    logic          moc;
    logic          cond_pass;
    logic          irq_req;
    logic [AW-1:0] index;
    logic [2:0]    stk_depth;
    logic          stk_err;
    logic          timeout;

    modport master (
        output stall, ns, inv, cs, cr_addr, enc_addr, moc, cond_pass, irq_req,
        input  index, stk_depth, stk_err, timeout
    );

    modport slave (
        input  stall, ns, inv, cs, cr_addr, enc_addr, moc, cond_pass, irq_req,
        output index, stk_depth, stk_err, timeout
    );
endinterface

// File: rtl/microsequencer.sv
// Microprogram counter with next-address select, a small return stack and a wait watchdog.
// index is registered; the combinational ROM word at index steers the next edge.
module microsequencer #(
    parameter int unsigned AW         = 7,
    parameter int unsigned STK_DEPTH  = 4,
    parameter int unsigned WAIT_MAX   = 255,
    parameter int unsigned FETCH_ADDR = 0,
    parameter int unsigned FAULT_ADDR = 0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    microsequencer_if.slave         sif
);
    localparam int unsigned PW = (STK_DEPTH > 1) ? $clog2(STK_DEPTH) : 1;
    localparam int unsigned DW = $clog2(STK_DEPTH + 1);
    localparam int unsigned WW = $clog2(WAIT_MAX + 1);

    localparam logic [AW-1:0] FETCH_A = AW'(FETCH_ADDR);
    localparam logic [AW-1:0] FAULT_A = AW'(FAULT_ADDR);

    typedef enum logic [2:0] {
        NS_ENC   = 3'b000,
        NS_FETCH = 3'b001,
        NS_INC   = 3'b010,
        NS_BR    = 3'b011,
        NS_BRENC = 3'b100,
        NS_WAIT  = 3'b101,
        NS_CALL  = 3'b110,
        NS_RET   = 3'b111
    } ns_e;

    logic [AW-1:0]                 index_q, index_d;
    logic [DW-1:0]                 dep_q, dep_d;
    logic [STK_DEPTH-1:0][AW-1:0]  stk_q;
    logic [WW-1:0]                 wcnt_q, wcnt_d;
    logic                          err_q, err_d;
    logic                          to_q, to_d;

    logic                          push;
    logic [AW-1:0]                 inc;
    logic [DW-1:0]                 top;
    logic                          cond_sel, c;
    logic                          full, empty;
    ns_e                           ns;

    assign ns    = ns_e'(sif.ns);
    assign inc   = index_q + 1'b1;
    assign top   = dep_q - 1'b1;
    assign full  = (dep_q == DW'(STK_DEPTH));
    assign empty = (dep_q == '0);

    // Full decode of cs keeps unused inputs from leaking X into c.
    always_comb begin
        cond_sel = 1'b1;
        case (sif.cs)
            2'b00:   cond_sel = 1'b1;
            2'b01:   cond_sel = sif.moc;
            2'b10:   cond_sel = sif.cond_pass;
            default: cond_sel = sif.irq_req;
        endcase
    end

    assign c = cond_sel ^ sif.inv;

    always_comb begin
        index_d = index_q;
        dep_d   = dep_q;
        wcnt_d  = wcnt_q;
        err_d   = err_q;
        to_d    = to_q;
        push    = 1'b0;
        if (!sif.stall) begin
            wcnt_d = '0;
            case (ns)
                NS_ENC:   index_d = sif.enc_addr;
                NS_FETCH: index_d = FETCH_A;
                NS_INC:   index_d = inc;
                NS_BR:    index_d = c ? sif.cr_addr : inc;
                NS_BRENC: index_d = c ? sif.enc_addr : inc;
                NS_WAIT: begin
                    // A satisfied condition always wins over an expiring watchdog.
                    if (c) begin
                        index_d = inc;
                    end else if (wcnt_q == WW'(WAIT_MAX - 1)) begin
                        index_d = FAULT_A;
                        to_d    = 1'b1;
                    end else begin
                        wcnt_d  = wcnt_q + 1'b1;
                    end
                end
                NS_CALL: begin
                    index_d = sif.cr_addr;
                    if (full) begin
                        err_d = 1'b1;
                    end else begin
                        push  = 1'b1;
                        dep_d = dep_q + 1'b1;
                    end
                end
                default: begin
                    if (empty) begin
                        err_d   = 1'b1;
                        index_d = FAULT_A;
                    end else begin
                        index_d = stk_q[top[PW-1:0]];
                        dep_d   = top;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            index_q <= FETCH_A;
            dep_q   <= '0;
            wcnt_q  <= '0;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
            stk_q   <= '0;
        end else begin
            index_q <= index_d;
            dep_q   <= dep_d;
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
            to_q    <= to_d;
            if (push)
                stk_q[dep_q[PW-1:0]] <= inc;
        end
    end

    // A full 8-deep stack cannot be shown in 3 bits; report it saturated.
    logic [3:0] dep4;
    assign dep4          = 4'(dep_q);
    assign sif.stk_depth = (dep4 > 4'd7) ? 3'd7 : dep4[2:0];
    assign sif.index     = index_q;
    assign sif.stk_err   = err_q;
    assign sif.timeout   = to_q;

endmodule

// File: tb/tb_microsequencer.sv
// Directed bench for microsequencer: a vector table for single-step next-address
// selection plus hand-written sequences for reset, wait, watchdog, stack and stall.
module tb_microsequencer;
    localparam int unsigned AW = 7;
    localparam logic [6:0] FAULT = 7'h7E;

    logic clk;
    logic reset_n;
    int   n_chk;
    int   n_fail;

    microsequencer_if #(.AW(AW)) sif ();

    microsequencer #(
        .AW(AW), .STK_DEPTH(4), .WAIT_MAX(4), .FETCH_ADDR(0), .FAULT_ADDR(7'h7E)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .sif     (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      nm;
        logic [6:0] st;
        logic [2:0] ns;
        logic       inv;
        logic [1:0] cs;
        logic [6:0] cr;
        logic [6:0] enc;
        logic       moc;
        logic       cp;
        logic       irq;
        logic [6:0] exp;
    } vec_t;

    vec_t vt[14];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        sif.stall = 1'b0; sif.ns = 3'b010; sif.inv = 1'b0; sif.cs = 2'b00;
        sif.cr_addr = '0; sif.enc_addr = '0;
        sif.moc = 1'b0; sif.cond_pass = 1'b0; sif.irq_req = 1'b0;
    endtask

    task automatic goto(input logic [6:0] a);
        idle_inputs();
        sif.ns = 3'b000; sif.enc_addr = a;
        step();
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        #3;
        reset_n = 1'b1;
        step();
    endtask

    task automatic set_op(input logic [2:0] ns, input logic [6:0] cr);
        idle_inputs();
        sif.ns = ns; sif.cr_addr = cr;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        idle_inputs();
        reset_n = 1'b0;

        //             name          st     ns    inv cs     cr     enc    moc cp irq exp
        vt[0]  = '{"enc",        7'h10, 3'b000, 0, 2'b00, 7'h00, 7'h33, 0, 0, 0, 7'h33};
        vt[1]  = '{"fetch",      7'h10, 3'b001, 0, 2'b00, 7'h55, 7'h66, 0, 0, 0, 7'h00};
        vt[2]  = '{"inc",        7'h10, 3'b010, 0, 2'b00, 7'h55, 7'h66, 0, 0, 0, 7'h11};
        vt[3]  = '{"inc_wrap",   7'h7F, 3'b010, 0, 2'b00, 7'h55, 7'h66, 0, 0, 0, 7'h00};
        vt[4]  = '{"br_cp",      7'h20, 3'b011, 0, 2'b10, 7'h5B, 7'h00, 0, 1, 0, 7'h5B};
        vt[5]  = '{"br_cp_inv",  7'h20, 3'b011, 1, 2'b10, 7'h5B, 7'h00, 0, 1, 0, 7'h21};
        vt[6]  = '{"br_true",    7'h20, 3'b011, 0, 2'b00, 7'h44, 7'h00, 0, 0, 0, 7'h44};
        vt[7]  = '{"br_irq0",    7'h20, 3'b011, 0, 2'b11, 7'h44, 7'h00, 1, 1, 0, 7'h21};
        vt[8]  = '{"br_irq1",    7'h20, 3'b011, 0, 2'b11, 7'h44, 7'h00, 0, 0, 1, 7'h44};
        vt[9]  = '{"brenc_moc1", 7'h30, 3'b100, 0, 2'b01, 7'h11, 7'h4C, 1, 0, 0, 7'h4C};
        vt[10] = '{"brenc_moc0", 7'h30, 3'b100, 0, 2'b01, 7'h11, 7'h4C, 0, 1, 1, 7'h31};
        vt[11] = '{"wait_moc1",  7'h3A, 3'b101, 0, 2'b01, 7'h11, 7'h22, 1, 0, 0, 7'h3B};
        vt[12] = '{"wait_moc0",  7'h3A, 3'b101, 0, 2'b01, 7'h11, 7'h22, 0, 1, 1, 7'h3A};
        vt[13] = '{"wait_tinv",  7'h3A, 3'b101, 1, 2'b00, 7'h11, 7'h22, 1, 1, 1, 7'h3A};

        #2;
        chk("rst_index", sif.index, 0);
        chk("rst_depth", sif.stk_depth, 0);
        chk("rst_err", sif.stk_err, 0);
        chk("rst_timeout", sif.timeout, 0);
        #10 reset_n = 1'b1;
        step();

        foreach (vt[i]) begin
            goto(vt[i].st);
            sif.ns = vt[i].ns; sif.inv = vt[i].inv; sif.cs = vt[i].cs;
            sif.cr_addr = vt[i].cr; sif.enc_addr = vt[i].enc;
            sif.moc = vt[i].moc; sif.cond_pass = vt[i].cp; sif.irq_req = vt[i].irq;
            step();
            chk(vt[i].nm, sif.index, vt[i].exp);
        end
        chk("vec_depth", sif.stk_depth, 0);
        chk("vec_err", sif.stk_err, 0);

        // Asynchronous reset mid-run at index 0x2A, depth 2.
        goto(7'h05);
        set_op(3'b110, 7'h08); step();
        set_op(3'b110, 7'h2A); step();
        chk("pre_rst_index", sif.index, 7'h2A);
        chk("pre_rst_depth", sif.stk_depth, 2);
        idle_inputs();
        #3 reset_n = 1'b0;
        #1;
        chk("async_rst_index", sif.index, 0);
        chk("async_rst_depth", sif.stk_depth, 0);
        chk("async_rst_err", sif.stk_err, 0);
        #1 reset_n = 1'b1;
        step();

        // Wait satisfied on the cycle the watchdog would otherwise expire.
        goto(7'h30);
        set_op(3'b101, 7'h00); sif.cs = 2'b01; sif.moc = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("wait_hold", sif.index, 7'h30);
        end
        sif.moc = 1'b1;
        step();
        chk("wait_release", sif.index, 7'h31);
        chk("wait_no_timeout", sif.timeout, 0);

        // Watchdog expiry with WAIT_MAX=4.
        goto(7'h40);
        chk("wd_first", sif.index, 7'h40);
        set_op(3'b101, 7'h00); sif.cs = 2'b01; sif.moc = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("wd_hold", sif.index, 7'h40);
            chk("wd_timeout_low", sif.timeout, 0);
        end
        step();
        chk("wd_fault", sif.index, FAULT);
        chk("wd_timeout", sif.timeout, 1);
        set_op(3'b010, 7'h00); step();
        chk("wd_sticky_idx", sif.index, 7'h7F);
        chk("wd_sticky", sif.timeout, 1);

        // Call / return and stack limits.
        do_reset();
        chk("rst_clears_timeout", sif.timeout, 0);
        goto(7'h20);
        set_op(3'b110, 7'h10); step();
        chk("call_idx", sif.index, 7'h10);
        chk("call_depth", sif.stk_depth, 1);
        set_op(3'b111, 7'h55); step();
        chk("ret_idx", sif.index, 7'h21);
        chk("ret_depth", sif.stk_depth, 0);
        goto(7'h01);
        for (int k = 0; k < 4; k++) begin
            set_op(3'b110, 7'(k + 2)); step();
        end
        chk("nest_depth4", sif.stk_depth, 4);
        chk("nest_err0", sif.stk_err, 0);
        set_op(3'b110, 7'h06); step();
        chk("ovf_idx", sif.index, 7'h06);
        chk("ovf_err", sif.stk_err, 1);
        chk("ovf_depth", sif.stk_depth, 4);
        for (int k = 0; k < 4; k++) begin
            set_op(3'b111, 7'h00); step();
            chk("unwind_idx", sif.index, 7'h05 - k);
            chk("unwind_depth", sif.stk_depth, 3 - k);
        end
        set_op(3'b111, 7'h00); step();
        chk("udf_idx", sif.index, FAULT);
        chk("udf_depth", sif.stk_depth, 0);
        chk("udf_err", sif.stk_err, 1);

        // Stall during INC and during a partially counted WAIT.
        do_reset();
        chk("rst_clears_err", sif.stk_err, 0);
        goto(7'h5F);
        set_op(3'b110, 7'h50); step();
        set_op(3'b010, 7'h00); sif.stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_inc_idx", sif.index, 7'h50);
            chk("stall_inc_depth", sif.stk_depth, 1);
        end
        sif.stall = 1'b0;
        step();
        chk("stall_inc_resume", sif.index, 7'h51);
        goto(7'h60);
        set_op(3'b101, 7'h00); sif.cs = 2'b01; sif.moc = 1'b0;
        step(); step();
        sif.stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_wait_idx", sif.index, 7'h60);
            chk("stall_wait_to", sif.timeout, 0);
        end
        sif.stall = 1'b0;
        step();
        chk("stall_wait_cnt3", sif.index, 7'h60);
        step();
        chk("stall_wait_fault", sif.index, FAULT);
        chk("stall_wait_timeout", sif.timeout, 1);
        chk("stall_wait_depth", sif.stk_depth, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
